alu_mdu_seq: RTL and testbench

//   Parametrised execute-stage ALU with an iterative multiply/divide unit (RV32M subset).
//   - Single-cycle ops: base logic/arith/compare/shift, registered on the output.
//   - MUL*/DIV*/REM*: shift-add and restoring-divide, one bit per cycle.
//   - EX stage connects through a valid/ready handshake; the hazard unit stalls on in_ready=0.

---
 rtl/alu_mdu_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_alu_mdu_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: execute-stage ALU with an iterative RV32M-style multiply/divide unit.
// Base ops complete in a single registered cycle. MUL*/DIV*/REM* run a shift-add or
// restoring-divide datapath one bit per cycle. Both share the hi/lo/opnd registers.
module alu_mdu_seq #(
    parameter int XLEN      = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_AND    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_XOR    = 5'd4;
    localparam logic [4:0] OP_SLT    = 5'd5;
    localparam logic [4:0] OP_SLTU   = 5'd6;
    localparam logic [4:0] OP_SLL    = 5'd7;
    localparam logic [4:0] OP_SRL    = 5'd8;
    localparam logic [4:0] OP_SRA    = 5'd9;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_REM    = 5'd22;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    logic [2:0]      op_q;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opnd;
    logic [SHW-1:0]  count;
    logic            neg_q;
    logic            neg_r;

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] base_res;

    logic            is_mop;
    logic            is_div;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic            div_zero;
    logic            div_ovf;
    logic            take_fast;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] fast_res;

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic [XLEN-1:0] hi_nxt;
    logic [XLEN-1:0] lo_nxt;

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   mdu_res;

    assign shamt     = b[SHW-1:0];
    assign in_ready  = (state == IDLE);
    assign zero      = out_valid && (result == '0);

    // Single-cycle base ALU evaluated on the live operands; only ever captured into result at acceptance.
    always_comb begin
        base_res = '0;
        case (alu_op)
            OP_ADD:  base_res = a + b;
            OP_SUB:  base_res = a - b;
            OP_AND:  base_res = a & b;
            OP_OR:   base_res = a | b;
            OP_XOR:  base_res = a ^ b;
            OP_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (a < b)};
            OP_SLL:  base_res = a << shamt;
            OP_SRL:  base_res = a >> shamt;
            OP_SRA:  base_res = $signed(a) >>> shamt;
            default: base_res = '0;
        endcase
    end

    // Decode M ops, take operand magnitudes and pick out the cases that finish in one cycle.
    always_comb begin
        is_mop    = (alu_op[4:3] == 2'b10);
        is_div    = is_mop && alu_op[2];
        a_signed  = (alu_op == OP_MULH) || (alu_op == OP_MULHSU) ||
                    (alu_op == OP_DIV)  || (alu_op == OP_REM);
        b_signed  = (alu_op == OP_MULH) || (alu_op == OP_DIV) || (alu_op == OP_REM);
        a_neg     = a_signed && a[XLEN-1];
        b_neg     = b_signed && b[XLEN-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        div_zero  = (b == '0);
        div_ovf   = ((alu_op == OP_DIV) || (alu_op == OP_REM)) && (a == MIN_INT) && (b == ALL_ONES);
        take_fast = !is_mop || !MULDIV_EN || (is_div && (div_zero || div_ovf));
        if (!is_mop) begin
            fast_res = base_res;
        end else if (!MULDIV_EN) begin
            fast_res = '0;
        end else if (is_div && div_zero) begin
            fast_res = alu_op[1] ? a : ALL_ONES;
        end else if (is_div && div_ovf) begin
            fast_res = alu_op[1] ? '0 : a;
        end else begin
            fast_res = '0;
        end
    end

    // One multiply or divide step: shift-add keeps the product in {hi,lo}, restoring divide keeps {rem,quo}.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
                hi_nxt = div_diff[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = div_shift[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_nxt = mul_sum[XLEN:1];
            lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    // Restore operand signs on the final step and select the half or quotient/remainder the opcode asks for.
    always_comb begin
        prod     = {hi_nxt, lo_nxt};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -lo_nxt : lo_nxt;
        rem_fix  = neg_r ? -hi_nxt : hi_nxt;
        if (op_q[2]) begin
            mdu_res = op_q[1] ? rem_fix : quo_fix;
        end else begin
            mdu_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

    // Control FSM and datapath registers; reset beats flush, and flush beats a new request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            op_q      <= '0;
            hi        <= '0;
            lo        <= '0;
            opnd      <= '0;
            count     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!flush && in_valid) begin
                        op_q <= alu_op[2:0];
                        if (take_fast) begin
                            result    <= fast_res;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            hi    <= '0;
                            lo    <= a_mag;
                            opnd  <= b_mag;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                            count <= SHW'(XLEN-1);
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        hi <= hi_nxt;
                        lo <= lo_nxt;
                        if (count == '0) begin
                            result    <= mdu_res;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            count <= count - SHW'(1);
                        end
                    end
                end
                DONE: begin
                    if (flush || out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb_alu_mdu_seq: directed, self-checking bench for alu_mdu_seq at XLEN=32.
// Expected values are hand-computed constants; operands are scrambled after
// acceptance so that results must come from the unit's own copies.
module tb_alu_mdu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic busyOk;
    logic holdOk;
    logic quietOk;

    alu_mdu_seq #(
        .XLEN      (32),
        .MULDIV_EN (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) begin
            passed++;
        end else begin
            fails++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) begin
            passed++;
        end else begin
            fails++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        alu_op   = op;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        alu_op   = 5'd31;
        a        = 32'hDEADBEEF;
        b        = 32'h0BADF00D;
    endtask

    task automatic waitValid(input string tag, input int budget);
        int n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checkBit({tag, " done"}, out_valid, 1'b1);
    endtask

    task automatic runFast(input string tag, input logic [4:0] op, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] exp);
        applyStimulus(op, x, y);
        checkBit({tag, " valid"}, out_valid, 1'b1);
        checkOutput(tag, result, exp);
        checkBit({tag, " zero"}, zero, (exp == 32'd0));
        tick();
    endtask

    task automatic runMdu(input string tag, input logic [4:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp);
        applyStimulus(op, x, y);
        waitValid(tag, 40);
        checkOutput(tag, result, exp);
        tick();
    endtask

    // Directed sequence: reset, base ops, M ops, backpressure, flush and mid-op reset.
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        alu_op    = 5'd0;
        a         = 32'd0;
        b         = 32'd0;
        tick();
        tick();
        checkBit("reset out_valid", out_valid, 1'b0);
        checkBit("reset in_ready", in_ready, 1'b1);
        checkOutput("reset result", result, 32'd0);
        checkBit("reset zero", zero, 1'b0);
        rst_n = 1'b1;
        tick();

        $display("[TB] base ops");
        runFast("ADD wrap", 5'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000);
        runFast("SUB equal", 5'd1, 32'd5, 32'd5, 32'd0);
        runFast("AND", 5'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0);
        runFast("OR", 5'd3, 32'h12340000, 32'h00005678, 32'h12345678);
        runFast("XOR", 5'd4, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F);
        runFast("SLT -1<1", 5'd5, 32'hFFFFFFFF, 32'h00000001, 32'd1);
        runFast("SLTU max<1", 5'd6, 32'hFFFFFFFF, 32'h00000001, 32'd0);
        runFast("SLL upper b ignored", 5'd7, 32'h00000001, 32'h00000021, 32'h00000002);
        runFast("SRL", 5'd8, 32'h80000000, 32'd31, 32'h00000001);
        runFast("SRA b=0x24", 5'd9, 32'h80000000, 32'h00000024, 32'hF8000000);
        runFast("undefined op", 5'd10, 32'h12345678, 32'h11111111, 32'd0);

        $display("[TB] divide special cases");
        runFast("DIVU by zero", 5'd21, 32'd7, 32'd0, 32'hFFFFFFFF);
        runFast("REMU by zero", 5'd23, 32'd7, 32'd0, 32'd7);
        runFast("DIV overflow", 5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        runFast("REM overflow", 5'd22, 32'h80000000, 32'hFFFFFFFF, 32'd0);

        $display("[TB] MULH latency");
        applyStimulus(5'd17, 32'h80000000, 32'h80000000);
        busyOk = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) busyOk = 1'b0;
            tick();
        end
        checkBit("MULH busy window", busyOk, 1'b1);
        checkBit("MULH valid at cycle 33", out_valid, 1'b1);
        checkOutput("MULH min*min", result, 32'h40000000);
        tick();

        $display("[TB] multiply and divide");
        runMdu("MUL min*min", 5'd16, 32'h80000000, 32'h80000000, 32'd0);
        runMdu("MUL -3*7", 5'd16, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB);
        runMdu("MULH -3*7", 5'd17, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF);
        runMdu("MULHU max*max", 5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        runMdu("MULHSU -1*2", 5'd18, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
        runMdu("DIV -7/2", 5'd20, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        runMdu("REM -7%2", 5'd22, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        runMdu("DIV 7/-2", 5'd20, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD);
        runMdu("REM 7%-2", 5'd22, 32'd7, 32'hFFFFFFFE, 32'd1);
        runMdu("REMU 100%7", 5'd23, 32'd100, 32'd7, 32'd2);

        $display("[TB] output backpressure");
        out_ready = 1'b0;
        applyStimulus(5'd21, 32'd100, 32'd7);
        waitValid("DIVU hold", 40);
        checkOutput("DIVU 100/7", result, 32'd14);
        holdOk = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid !== 1'b1 || result !== 32'd14 || in_ready !== 1'b0) holdOk = 1'b0;
        end
        checkBit("hold stable", holdOk, 1'b1);
        out_ready = 1'b1;
        tick();
        checkBit("release in_ready", in_ready, 1'b1);
        checkBit("release out_valid", out_valid, 1'b0);

        $display("[TB] flush in BUSY");
        applyStimulus(5'd21, 32'hFFFFFFFF, 32'd3);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkBit("flush in_ready", in_ready, 1'b1);
        checkBit("flush out_valid", out_valid, 1'b0);
        checkOutput("flush result held", result, 32'd14);
        quietOk = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid !== 1'b0) quietOk = 1'b0;
        end
        checkBit("flush no output", quietOk, 1'b1);

        $display("[TB] flush in IDLE");
        alu_op   = 5'd0;
        a        = 32'd1;
        b        = 32'd1;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        checkBit("idle flush blocks accept", out_valid, 1'b0);
        checkBit("idle flush in_ready", in_ready, 1'b1);

        $display("[TB] reset mid-op");
        applyStimulus(5'd16, 32'd3, 32'd5);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("mid-op reset result", result, 32'd0);
        checkBit("mid-op reset out_valid", out_valid, 1'b0);
        checkBit("mid-op reset in_ready", in_ready, 1'b1);
        runFast("ADD after reset", 5'd0, 32'd2, 32'd3, 32'd5);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
